// File: rtl/thirty_two_bit_serial_subtractor.sv
// Digit-serial 32-bit unsigned subtractor.
// Computes diff = a - b (mod 2^32) DIGIT_W bits per clock, LSB slice first,
// rippling the borrow between slices through a register.
//
// Parameters:
//   DIGIT_W  bits processed per RUN cycle (1, 2, 4, 8, 16 or 32)
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, sampled only while idle
//   a, b    minuend / subtrahend, captured on the accepting edge
//   diff    registered result a - b mod 2^32, valid from done onward
//   borrow  registered borrow-out, 1 iff a < b
//   zero    registered flag, 1 iff the completed diff is 0
//   busy    high while running or signalling done
//   done    one-cycle completion pulse
module thirty_two_bit_serial_subtractor #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam int unsigned N     = 32 / DIGIT_W;
  localparam logic [5:0]  KLast = 6'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        brw_q, brw_d;
  logic [31:0] diff_q, diff_d;
  logic        borrow_q, borrow_d;
  logic        zero_q, zero_d;

  // Slice datapath
  int unsigned        base;
  logic [DIGIT_W-1:0] a_s;
  logic [DIGIT_W-1:0] b_s;
  logic [DIGIT_W:0]   sub;
  logic [31:0]        diff_run;
  logic               last;

  always_comb begin
    base     = {26'd0, k_q} * DIGIT_W;
    a_s      = a_q[base +: DIGIT_W];
    b_s      = b_q[base +: DIGIT_W];
    // Extra MSB of the difference is the slice borrow-out.
    sub      = {1'b0, a_s} - {1'b0, b_s} - {{DIGIT_W{1'b0}}, brw_q};
    diff_run = diff_q;
    diff_run[base +: DIGIT_W] = sub[DIGIT_W-1:0];
    last     = (k_q == KLast);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = 1'b0;
          k_d     = 6'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        diff_d = diff_run;
        brw_d  = sub[DIGIT_W];
        k_d    = k_q + 6'd1;
        // borrow/zero keep the previous result until the final slice lands.
        if (last) begin
          borrow_d = sub[DIGIT_W];
          zero_d   = (diff_run == 32'd0);
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      brw_q    <= 1'b0;
      diff_q   <= 32'd0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign busy   = (state_q == StRun) || (state_q == StDone);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_thirty_two_bit_serial_subtractor.sv
module tb_thirty_two_bit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] diff;
  logic        borrow, zero, busy, done;

  // Shared stimulus for the DIGIT_W=1 and DIGIT_W=32 builds
  logic        st2;
  logic [31:0] a2, b2;
  logic [31:0] diff_w1, diff_w32;
  logic        borrow_w1, zero_w1, busy_w1, done_w1;
  logic        borrow_w32, zero_w32, busy_w32, done_w32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thirty_two_bit_serial_subtractor #(.DIGIT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .zero(zero), .busy(busy), .done(done)
  );

  thirty_two_bit_serial_subtractor #(.DIGIT_W(1)) dut_w1 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
    .diff(diff_w1), .borrow(borrow_w1), .zero(zero_w1), .busy(busy_w1), .done(done_w1)
  );

  thirty_two_bit_serial_subtractor #(.DIGIT_W(32)) dut_w32 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
    .diff(diff_w32), .borrow(borrow_w32), .zero(zero_w32), .busy(busy_w32), .done(done_w32)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One operation on the DIGIT_W=4 build. lat counts sampled edges starting
  // with the accepting one, so latency = lat - 1. mid holds {borrow, zero}
  // sampled in the middle of RUN. Returns with the DUT back in IDLE.
  task automatic op4(input logic [31:0] av, input logic [31:0] bv,
                     output int lat, output int bcnt, output logic [1:0] mid);
    a = av; b = bv; start = 1'b1;
    lat = 0; bcnt = 0; mid = 2'b00;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 4) mid = {borrow, zero};
      if (busy) bcnt++;
      if (done) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, bcnt, nd, c1, c2;
    int lat_w1, lat_w32;
    logic [1:0]  mid;
    logic [31:0] dsave, dw1, dw32;
    logic        bw1, bw32;

    // Reset held with start high: must stay idle and cleared.
    rst = 1'b1; start = 1'b1; a = 32'h5; b = 32'h3;
    st2 = 1'b0; a2 = 32'd0; b2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_diff", diff, 32'd0);
    check_val("rst_borrow", 32'(borrow), 32'd0);
    check_val("rst_zero", 32'(zero), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 5 - 3
    op4(32'h5, 32'h3, lat, bcnt, mid);
    check_val("t1_latency", 32'(lat - 1), 32'd8);
    check_val("t1_busy_cycles", 32'(bcnt), 32'd9);
    check_val("t1_diff", diff, 32'h2);
    check_val("t1_borrow", 32'(borrow), 32'd0);
    check_val("t1_zero", 32'(zero), 32'd0);
    check_val("t1_done_low", 32'(done), 32'd0);
    check_val("t1_busy_low", 32'(busy), 32'd0);
    a = 32'hFFFF_0000; b = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check_val("t1_hold_diff", diff, 32'h2);

    // 0 - 1: borrow ripples through every slice
    op4(32'h0, 32'h1, lat, bcnt, mid);
    check_val("t2_diff", diff, 32'hFFFF_FFFF);
    check_val("t2_borrow", 32'(borrow), 32'd1);
    check_val("t2_zero", 32'(zero), 32'd0);

    // Equal operands; flags from previous result must hold during RUN
    op4(32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, bcnt, mid);
    check_val("t3_mid_flags", 32'(mid), 32'h2);
    check_val("t3_diff", diff, 32'h0);
    check_val("t3_borrow", 32'(borrow), 32'd0);
    check_val("t3_zero", 32'(zero), 32'd1);

    // START during RUN ignored, A/B changes ignored
    a = 32'd10; b = 32'd4; start = 1'b1;
    nd = 0; dsave = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 3) begin a = 32'd1; b = 32'd2; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin nd++; dsave = diff; end
    end
    check_val("t4_done_count", 32'(nd), 32'd1);
    check_val("t4_diff", dsave, 32'h6);
    check_val("t4_borrow", 32'(borrow), 32'd0);

    // Reset mid-RUN aborts
    a = 32'h1234_5678; b = 32'h1; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_val("t5_rst_diff", diff, 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check_val("t5_no_done", 32'(nd), 32'd0);
    op4(32'h1234_5678, 32'h1, lat, bcnt, mid);
    check_val("t5_latency", 32'(lat - 1), 32'd8);
    check_val("t5_diff", diff, 32'h1234_5677);

    // START held high: one result every N+2 cycles
    a = 32'd7; b = 32'd3; start = 1'b1;
    c1 = -1; c2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (c1 < 0) c1 = i;
        else begin c2 = i; break; end
      end
    end
    start = 1'b0;
    check_val("t6_period", 32'(c2 - c1), 32'd10);
    check_val("t6_diff", diff, 32'h4);
    repeat (2) @(posedge clk);
    #1;

    // DIGIT_W=1 and DIGIT_W=32 builds
    a2 = 32'h8000_0000; b2 = 32'h1; st2 = 1'b1;
    lat_w1 = 999; lat_w32 = 999;
    dw1 = 32'd0; dw32 = 32'd0; bw1 = 1'b1; bw32 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) st2 = 1'b0;
      if (done_w1)  begin lat_w1  = i; dw1  = diff_w1;  bw1  = borrow_w1;  end
      if (done_w32) begin lat_w32 = i; dw32 = diff_w32; bw32 = borrow_w32; end
    end
    check_val("w1_latency", 32'(lat_w1 - 1), 32'd32);
    check_val("w1_diff", dw1, 32'h7FFF_FFFF);
    check_val("w1_borrow", 32'(bw1), 32'd0);
    check_val("w32_latency", 32'(lat_w32 - 1), 32'd1);
    check_val("w32_diff", dw32, 32'h7FFF_FFFF);
    check_val("w32_borrow", 32'(bw32), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
